dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AW, 32, address width of all address ports.
REQ-002 Parameter DW, 32, data width of all data ports.
REQ-003 Parameter RD_LAT, 1, RAM read latency in cycles from address presentation to valid mem_rdata; legal range 0..3.
REQ-004 clock  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 cpu_req  in  1  pipeline data-port request; held high until cpu_ack.
REQ-007 cpu_we  in  1  1 = write, 0 = read; valid while cpu_req.
REQ-008 cpu_addr  in  AW  pipeline access address.
REQ-009 cpu_wdata  in  DW  pipeline write data.
REQ-010 cpu_rdata  out  DW  read data; valid in the cpu_ack cycle.
REQ-011 cpu_ack  out  1  one-cycle completion pulse.
REQ-012 cpu_stall  out  1  pipeline hold = cpu_req & ~cpu_ack.
REQ-013 dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_rdata, dbg_ack  same directions, widths and meanings as cpu_* for the debug/loader port.
REQ-014 mem_addr  out  AW  RAM address, registered.
REQ-015 mem_wdata  out  DW  RAM write data, registered.
REQ-016 mem_wr_en  out  1  RAM write strobe, registered.
REQ-017 mem_rdata  in  DW  RAM read data.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 FSM states: IDLE, ACCESS, WAIT, RESP.
REQ-020 IDLE: when any req is sampled high, latch the winner's id, we, addr and wdata, then go to ACCESS; otherwise stay in IDLE.
REQ-021 Arbitration: round-robin between the two requesters; a single requester always wins; on a simultaneous request the requester not served last wins.
REQ-022 ACCESS: drive the latched mem_addr; drive mem_wr_en = 1 for exactly this one cycle on a write.
REQ-023 ACCESS transitions: a write, or a read with RD_LAT = 0, goes to RESP; a read with RD_LAT > 0 goes to WAIT.
REQ-024 WAIT: a down-counter runs for RD_LAT cycles with mem_addr held stable, then the FSM goes to RESP.
REQ-025 Read data: mem_rdata is captured into the winner's rdata register on the final ACCESS/WAIT cycle.
REQ-026 RESP: the winner's ack is high for one cycle, the last-served flag is updated, and the FSM goes to IDLE.
REQ-027 Latency, request first sampled in cycle N:
- write ack in cycle N+2;
- read ack in cycle N+2+RD_LAT.
REQ-028 Handshake: a requester deasserts req in the cycle after its ack; a minimum of one IDLE cycle separates transactions.
REQ-029 Stability: addr, we and wdata changes after the grant have no effect on the transaction in flight.
REQ-030 Non-winning outputs: the loser's ack stays 0 and its rdata holds its previous value.
REQ-031 Outside the ACCESS cycle mem_wr_en = 0; mem_addr and mem_wdata hold their last values.
REQ-032 A req arriving while busy waits; it is never dropped and never partially served.

Reset
REQ-033 While reset is high at a clock edge: state = IDLE, mem_wr_en = 0, both acks = 0, busy = 0, mem_addr/mem_wdata/cpu_rdata/dbg_rdata = 0, WAIT counter = 0, last-served = dbg (so cpu wins the first tie).
REQ-034 Reset mid-transaction aborts it with no ack; a write strobe issued before the reset edge is not undone.
REQ-035 An access may start in the first cycle after reset deasserts.

Structure
REQ-036 Package dlx_mem_pkg holds the FSM state encoding, the requester-id constants (ID_CPU, ID_DBG) and the default AW/DW/RD_LAT values.
REQ-037 The two-way round-robin grant logic is one sub-module, rr_arb2 (inputs req[1:0], last; output gnt[1:0]).

Verification
REQ-038 cpu write: cpu_req=1, we=1, addr=0x8, wdata=0x1E in cycle N -> mem_wr_en=1 with addr 0x8 and data 0x1E only in N+1; cpu_ack in N+2.
REQ-039 cpu read after that write, RD_LAT=1: addr=0x8 -> cpu_ack in N+3 with cpu_rdata=0x1E; cpu_stall high N..N+2 and low in N+3.
REQ-040 Simultaneous cpu and dbg read right after reset -> cpu served first, dbg next; dbg_ack one transaction later and never in the same cycle as cpu_ack.
REQ-041 Both requesters request continuously for 6 transactions -> grants alternate cpu, dbg, cpu, ...; no ack is lost.
REQ-042 Reset asserted in the WAIT cycle of a read -> no ack, state IDLE, busy=0 on the next cycle; a new request is served normally afterwards.
REQ-043 RD_LAT=0 and RD_LAT=3 builds -> read ack in N+2 and N+5 respectively, with correct data.

Source files
------------

// File: rtl/dlx_mem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, requester ids
// and default bus/latency parameters.
package dlx_mem_pkg;

    localparam int DEF_AW     = 32;
    localparam int DEF_DW     = 32;
    localparam int DEF_RD_LAT = 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    // Requester ids double as bit positions in the req/gnt vectors.
    localparam logic ID_CPU = 1'b0;
    localparam logic ID_DBG = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins; on a tie the
// requester that was not served last wins.
module rr_arb2
    import dlx_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last == ID_DBG) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data RAM between the pipeline (cpu) and the
// debug/loader (dbg) port; one transaction in flight at a time.
module dmem_arbiter
    import dlx_mem_pkg::*;
#(
    parameter int AW     = DEF_AW,
    parameter int DW     = DEF_DW,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic          clock,
    input  logic          reset,
    // req/ack handshake: a requester raises req with we/addr/wdata and holds it
    // until its one-cycle ack; rdata is valid in the ack cycle; req drops the
    // cycle after ack, and request fields are only sampled at the grant.
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_ack,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_wr_en,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output state_t        fsm_state
);

    localparam logic [1:0] WAIT_INIT = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

    state_t        state;
    logic [1:0]    req_vec;
    logic [1:0]    gnt;
    logic          last_id;
    logic          cur_id;
    logic          cur_we;
    logic [1:0]    wait_cnt;
    logic          win_id;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;
    logic          finish;

    assign req_vec = {dbg_req, cpu_req};

    rr_arb2 u_rr_arb2 (
        .req  (req_vec),
        .last (last_id),
        .gnt  (gnt)
    );

    assign win_id    = gnt[ID_DBG] ? ID_DBG : ID_CPU;
    assign win_we    = (win_id == ID_DBG) ? dbg_we    : cpu_we;
    assign win_addr  = (win_id == ID_DBG) ? dbg_addr  : cpu_addr;
    assign win_wdata = (win_id == ID_DBG) ? dbg_wdata : cpu_wdata;

    // Last ACCESS/WAIT cycle: mem_rdata is valid here for a read.
    assign finish = ((state == S_ACCESS) && (cur_we || (RD_LAT == 0))) ||
                    ((state == S_WAIT) && (wait_cnt == 2'd0));

    assign busy      = (state != S_IDLE);
    assign fsm_state = state;
    assign cpu_stall = cpu_req & ~cpu_ack;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            mem_wr_en <= 1'b0;
            cpu_ack   <= 1'b0;
            dbg_ack   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
            wait_cnt  <= 2'd0;
            last_id   <= ID_DBG;
            cur_id    <= ID_CPU;
            cur_we    <= 1'b0;
        end else begin
            mem_wr_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|gnt) begin
                        cur_id    <= win_id;
                        cur_we    <= win_we;
                        mem_addr  <= win_addr;
                        mem_wdata <= win_wdata;
                        mem_wr_en <= win_we;
                        state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!finish) begin
                        wait_cnt <= WAIT_INIT;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!finish) begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                S_RESP: begin
                    cpu_ack <= 1'b0;
                    dbg_ack <= 1'b0;
                    last_id <= cur_id;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (finish) begin
                state   <= S_RESP;
                cpu_ack <= (cur_id == ID_CPU);
                dbg_ack <= (cur_id == ID_DBG);
                if (!cur_we) begin
                    if (cur_id == ID_CPU) cpu_rdata <= mem_rdata;
                    else                  dbg_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three builds (RD_LAT 1, 0, 3) each with a RAM model;
// directed timing checks plus randomized two-requester traffic vs a serial memory model.
module tb_dmem_arbiter;
  import dlx_mem_pkg::*;

  localparam int W = 32;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic ram_init = 1'b1;
  int   cyc = 0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // index [k][r]: k = build (0: RD_LAT=1, 1: RD_LAT=0, 2: RD_LAT=3), r = 0 cpu / 1 dbg
  logic         rq   [3][2];
  logic         we_i [3][2];
  logic         ack  [3][2];
  logic [W-1:0] ad   [3][2];
  logic [W-1:0] wd   [3][2];
  logic [W-1:0] rd   [3][2];
  logic         stall[3];
  logic [W-1:0] mem_addr [3];
  logic [W-1:0] mem_wdata[3];
  logic [W-1:0] mem_rdata[3];
  logic         mem_wr_en[3];
  logic         busy     [3];
  state_t       fsm_state[3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : (g == 1) ? 0 : 3;
    logic [W-1:0] ram [16];
    logic [W-1:0] rd0;
    logic [W-1:0] pipe [1:3];

    dmem_arbiter #(.AW(W), .DW(W), .RD_LAT(L)) u_dut (
      .clock(clock), .reset(reset),
      .cpu_req(rq[g][0]), .cpu_we(we_i[g][0]), .cpu_addr(ad[g][0]), .cpu_wdata(wd[g][0]),
      .cpu_rdata(rd[g][0]), .cpu_ack(ack[g][0]), .cpu_stall(stall[g]),
      .dbg_req(rq[g][1]), .dbg_we(we_i[g][1]), .dbg_addr(ad[g][1]), .dbg_wdata(wd[g][1]),
      .dbg_rdata(rd[g][1]), .dbg_ack(ack[g][1]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_wr_en(mem_wr_en[g]),
      .mem_rdata(mem_rdata[g]), .busy(busy[g]), .fsm_state(fsm_state[g])
    );

    assign rd0 = ram[mem_addr[g][3:0]];
    always @(posedge clock) begin
      pipe[1] <= rd0;
      pipe[2] <= pipe[1];
      pipe[3] <= pipe[2];
      if (ram_init) begin
        for (int a = 0; a < 16; a++) ram[a] <= '0;
      end else if (mem_wr_en[g]) begin
        ram[mem_addr[g][3:0]] <= mem_wdata[g];
      end
    end
    if (L == 0) begin : g_l0
      assign mem_rdata[g] = rd0;
    end else begin : g_ln
      assign mem_rdata[g] = pipe[L];
    end
  end

  // scoreboard
  int n_checks = 0;
  int n_pass = 0;
  int writes_acked = 0;
  int wr_strobes = 0;
  logic [W-1:0] ref_mem [16];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // monitor on the RD_LAT=1 build: grant order, ack exclusivity, write strobes
  always @(negedge clock) begin
    if (!reset) begin
      if (ack[0][0] && ack[0][1]) check("ack_overlap", 1, 0);
      if (ack[0][0]) got_q.push_back(W'(0));
      if (ack[0][1]) got_q.push_back(W'(1));
      if (mem_wr_en[0]) wr_strobes++;
    end
  end

  // Solo transaction with exact cycle expectations; request fields are
  // scrambled the cycle after the grant.
  task automatic run_solo(input int k, input int r, input logic we, input logic [W-1:0] addr,
                          input logic [W-1:0] wdata, input int lat, input logic [W-1:0] exp_rd);
    int n, got_lat, strobes, other_acks;
    logic [W-1:0] other_rd;
    n = cyc; got_lat = -1; strobes = 0; other_acks = 0;
    other_rd = rd[k][1-r];
    rq[k][r] = 1'b1; we_i[k][r] = we; ad[k][r] = addr; wd[k][r] = wdata;
    for (int i = 0; i < 12 && got_lat < 0; i++) begin
      @(negedge clock);
      if (r == 0) check("cpu_stall", W'(stall[k]), W'((cyc - n) != lat));
      if (mem_wr_en[k]) begin
        strobes++;
        check("wr_cycle", cyc - n, 1);
        check("wr_addr", mem_addr[k], addr);
        check("wr_data", mem_wdata[k], wdata);
      end
      if (ack[k][1-r]) other_acks++;
      if (ack[k][r]) begin
        got_lat = cyc - n;
        if (!we) check("rdata", rd[k][r], exp_rd);
      end
      tick();
      if (cyc == n + 1) begin
        we_i[k][r] = ~we; ad[k][r] = ~addr; wd[k][r] = ~wdata;
      end
    end
    check("ack_latency", got_lat, lat);
    check("strobe_count", strobes, W'(we));
    check("loser_ack", other_acks, 0);
    check("loser_rdata", rd[k][1-r], other_rd);
    rq[k][r] = 1'b0;
    if (k == 0 && we) begin
      ref_mem[addr[3:0]] = wdata;
      writes_acked++;
    end
    tick();
  endtask

  // Transaction on the RD_LAT=1 build checked against the serial memory model.
  task automatic drive_txn(input int r, input logic we, input logic [W-1:0] addr,
                           input logic [W-1:0] wdata, output int lat);
    int n;
    n = cyc; lat = -1;
    rq[0][r] = 1'b1; we_i[0][r] = we; ad[0][r] = addr; wd[0][r] = wdata;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      @(negedge clock);
      if (ack[0][r]) begin
        lat = cyc - n;
        if (we) begin
          ref_mem[addr[3:0]] = wdata;
          writes_acked++;
        end else begin
          check(r ? "dbg_rdata" : "cpu_rdata", rd[0][r], ref_mem[addr[3:0]]);
        end
      end
      tick();
    end
    if (lat < 0) check("txn_timeout", 0, 1);
    rq[0][r] = 1'b0;
    tick();
  endtask

  task automatic check_order(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check(tag, got_q[i], exp_q[i]);
  endtask

  task automatic expect_alternation(input int n_txn);
    logic last_m;
    last_m = 1'b1;
    for (int i = 0; i < n_txn; i++) begin
      last_m = ~last_m;
      exp_q.push_back(W'(last_m));
    end
  endtask

  initial begin
    int lat_c, lat_d, acks;
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 2; r++) begin
        rq[k][r] = 1'b0; we_i[k][r] = 1'b0; ad[k][r] = '0; wd[k][r] = '0;
      end
    end
    for (int a = 0; a < 16; a++) ref_mem[a] = '0;
    reset = 1'b1;
    repeat (3) tick();
    ram_init = 1'b0;
    reset = 1'b0;

    @(negedge clock);
    check("rst_state", fsm_state[0], S_IDLE);
    check("rst_busy", W'(busy[0]), 0);
    check("rst_cpu_ack", W'(ack[0][0]), 0);
    check("rst_dbg_ack", W'(ack[0][1]), 0);
    check("rst_wr_en", W'(mem_wr_en[0]), 0);
    check("rst_mem_addr", mem_addr[0], 0);
    check("rst_mem_wdata", mem_wdata[0], 0);
    check("rst_cpu_rdata", rd[0][0], 0);
    check("rst_dbg_rdata", rd[0][1], 0);
    check("rst_stall", W'(stall[0]), 0);
    tick();

    // directed single-requester timing on every build
    run_solo(0, 0, 1'b1, 'h8, 'h1E, 2, 0);
    run_solo(0, 0, 1'b0, 'h8, 0, 3, 'h1E);
    run_solo(0, 1, 1'b1, 'h3, 'hABCD1234, 2, 0);
    run_solo(0, 1, 1'b0, 'h3, 0, 3, 'hABCD1234);
    run_solo(0, 0, 1'b0, 'h3, 0, 3, 'hABCD1234);
    run_solo(1, 0, 1'b1, 'h5, 'h55AA, 2, 0);
    run_solo(1, 0, 1'b0, 'h5, 0, 2, 'h55AA);
    run_solo(2, 1, 1'b1, 'h6, 'h0F0F, 2, 0);
    run_solo(2, 1, 1'b0, 'h6, 0, 5, 'h0F0F);
    run_solo(2, 0, 1'b0, 'h6, 0, 5, 'h0F0F);

    // simultaneous reads in the first cycle after reset
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    got_q.delete(); exp_q.delete();
    expect_alternation(2);
    fork
      drive_txn(0, 1'b0, 'h8, 0, lat_c);
      drive_txn(1, 1'b0, 'h8, 0, lat_d);
    join
    check("tie_cpu_latency", lat_c, 3);
    check("tie_dbg_latency", lat_d, 7);
    check_order("tie_order");

    // both requesters continuously busy for six transactions
    got_q.delete(); exp_q.delete();
    expect_alternation(6);
    fork
      for (int i = 0; i < 3; i++) drive_txn(0, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom, lat_c);
      for (int i = 0; i < 3; i++) drive_txn(1, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom, lat_d);
    join
    check_order("rr_order");

    // reset during the WAIT cycle of a read aborts it
    rq[0][0] = 1'b1; we_i[0][0] = 1'b0; ad[0][0] = 'h4;
    repeat (2) tick();
    check("abort_in_wait", fsm_state[0], S_WAIT);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rq[0][0] = 1'b0;
    @(negedge clock);
    check("abort_state", fsm_state[0], S_IDLE);
    check("abort_busy", W'(busy[0]), 0);
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      if (ack[0][0] || ack[0][1]) acks++;
      @(negedge clock);
    end
    check("abort_no_ack", acks, 0);
    tick();
    run_solo(0, 0, 1'b1, 'h4, 'h600D, 2, 0);
    run_solo(0, 0, 1'b0, 'h4, 0, 3, 'h600D);

    // randomized traffic from both ports
    fork
      for (int i = 0; i < 15; i++) begin
        repeat ($urandom_range(0, 3)) tick();
        drive_txn(0, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom, lat_c);
      end
      for (int i = 0; i < 15; i++) begin
        repeat ($urandom_range(0, 3)) tick();
        drive_txn(1, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom, lat_d);
      end
    join
    repeat (2) tick();

    check("write_strobes", wr_strobes, writes_acked);
    for (int a = 0; a < 16; a++) check($sformatf("ram_%0d", a), g_dut[0].ram[a], ref_mem[a]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
